// File: rtl/sram_wb_port_ctrl_pkg.sv
// Shared types and constants for the Wishbone-to-SRAM port-0 controller.
package sram_wb_port_ctrl_pkg;

  localparam int unsigned SRAM_AW         = 8;
  localparam int unsigned SRAM_DW         = 32;
  localparam int unsigned SRAM_NUM_WMASKS = 4;
  localparam int unsigned SRAM_WIN_BITS   = 10;

  typedef enum logic [2:0] {
    StIdle,
    StWr,
    StRdIssue,
    StRdWait,
    StRdAck,
    StMiss
  } state_e;

endpackage

// File: rtl/sram_wb_port_ctrl.sv
// Wishbone classic slave driving the 1RW port of a 32x256 SRAM macro over a 1 KB window.
// Define SRAM_WB_PORT_CTRL_ERR_EN to answer out-of-window accesses with wbs_err_o instead of ack.
module sram_wb_port_ctrl
  import sram_wb_port_ctrl_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
  parameter int unsigned SRAM_AW    = 8,
  parameter int unsigned DW         = 32,
  parameter int unsigned NUM_WMASKS = 4
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic                  wbs_cyc_i,
  input  logic                  wbs_stb_i,
  input  logic                  wbs_we_i,
  input  logic [NUM_WMASKS-1:0] wbs_sel_i,
  input  logic [31:0]           wbs_adr_i,
  input  logic [DW-1:0]         wbs_dat_i,
  output logic                  wbs_ack_o,
  output logic                  wbs_err_o,
  output logic [DW-1:0]         wbs_dat_o,
  output logic                  sram_clk0,
  output logic                  sram_csb0,
  output logic                  sram_web0,
  output logic [NUM_WMASKS-1:0] sram_wmask0,
  output logic [SRAM_AW-1:0]    sram_addr0,
  output logic [DW-1:0]         sram_din0,
  input  logic [DW-1:0]         sram_dout0
);

  state_e                state_q, state_d;
  logic                  ack_q, ack_d;
  logic [DW-1:0]         dat_q, dat_d;
  logic                  csb_q, csb_d;
  logic                  web_q, web_d;
  logic [NUM_WMASKS-1:0] wmask_q, wmask_d;
  logic [SRAM_AW-1:0]    addr_q, addr_d;
  logic [DW-1:0]         din_q, din_d;
`ifdef SRAM_WB_PORT_CTRL_ERR_EN
  logic                  err_q, err_d;
`endif

  logic req;
  logic hit;
  logic unused_adr_bits;

  assign req = wbs_cyc_i & wbs_stb_i;
  assign hit = (wbs_adr_i[31:SRAM_WIN_BITS] == BASE_ADDR[31:SRAM_WIN_BITS]);
  assign unused_adr_bits = ^wbs_adr_i[1:0];

  always_comb begin
    state_d = state_q;
    ack_d   = 1'b0;
    dat_d   = dat_q;
    csb_d   = 1'b1;
    web_d   = 1'b1;
    wmask_d = wmask_q;
    addr_d  = addr_q;
    din_d   = din_q;
`ifdef SRAM_WB_PORT_CTRL_ERR_EN
    err_d   = 1'b0;
`endif
    case (state_q)
      StIdle: begin
        if (req) begin
          if (hit) begin
            addr_d  = wbs_adr_i[SRAM_AW+1:2];
            wmask_d = wbs_sel_i;
            csb_d   = 1'b0;
            if (wbs_we_i) begin
              // Write completes in one SRAM cycle, so ack goes out with the strobe.
              state_d = StWr;
              web_d   = 1'b0;
              din_d   = wbs_dat_i;
              ack_d   = 1'b1;
            end else begin
              state_d = StRdIssue;
            end
          end else begin
            state_d = StMiss;
`ifdef SRAM_WB_PORT_CTRL_ERR_EN
            err_d   = 1'b1;
`else
            ack_d   = 1'b1;
            dat_d   = '0;
`endif
          end
        end
      end
      StWr:      state_d = StIdle;
      StRdIssue: state_d = wbs_cyc_i ? StRdWait : StIdle;
      StRdWait: begin
        // dout0 settles after this cycle's negedge; an abandoned cycle keeps dat_o intact.
        if (wbs_cyc_i) begin
          state_d = StRdAck;
          ack_d   = 1'b1;
          dat_d   = sram_dout0;
        end else begin
          state_d = StIdle;
        end
      end
      StRdAck:   state_d = StIdle;
      StMiss:    state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= StIdle;
      ack_q   <= 1'b0;
      dat_q   <= '0;
      csb_q   <= 1'b1;
      web_q   <= 1'b1;
      wmask_q <= '0;
      addr_q  <= '0;
      din_q   <= '0;
`ifdef SRAM_WB_PORT_CTRL_ERR_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      dat_q   <= dat_d;
      csb_q   <= csb_d;
      web_q   <= web_d;
      wmask_q <= wmask_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
`ifdef SRAM_WB_PORT_CTRL_ERR_EN
      err_q   <= err_d;
`endif
    end
  end

  assign wbs_ack_o   = ack_q;
  assign wbs_dat_o   = dat_q;
`ifdef SRAM_WB_PORT_CTRL_ERR_EN
  assign wbs_err_o   = err_q;
`else
  assign wbs_err_o   = 1'b0;
`endif
  assign sram_clk0   = wb_clk_i;
  assign sram_csb0   = csb_q;
  assign sram_web0   = web_q;
  assign sram_wmask0 = wmask_q;
  assign sram_addr0  = addr_q;
  assign sram_din0   = din_q;

endmodule
